// File: rtl/pool_relu_13_2_12.sv
// rtl/pool_relu_13_2_12.sv - ReLU plus non-overlapping 1-D max-pool stage with valid/ready streams
`timescale 1ns/1ps

module pool_relu_13_2_12 #(
  parameter int L = 13,
  parameter int K = 2,
  parameter int T = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  output logic signed [T-1:0] m_data_out_y,
  output logic                m_valid_y,
  input  logic                m_ready_y
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int WW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(K - 1);

  logic [IW-1:0]       r_idx;
  logic [WW-1:0]       r_w;
  logic signed [T-1:0] r_runmax;
  logic signed [T-1:0] r_data;
  logic                r_valid;

  logic                w_close;
  logic                w_accept;
  logic signed [T-1:0] w_max;
  logic signed [T-1:0] w_relu;

  // Only a window-closing element needs the output slot, so only it can stall.
  always_comb begin
    w_close   = (r_w == W_LAST) || (r_idx == IDX_LAST);
    s_ready_x = !w_close || !r_valid || m_ready_y;
    w_accept  = s_valid_x && s_ready_x;
    w_max     = ((r_w == '0) || (s_data_in_x > r_runmax)) ? s_data_in_x : r_runmax;
    w_relu    = w_max[T-1] ? '0 : w_max;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_w      <= '0;
      r_runmax <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_runmax <= w_max;
        r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        r_w      <= w_close ? '0 : r_w + WW'(1);
      end
      // A load wins over a simultaneous drain: the slot stays full with new data.
      if (w_accept && w_close) begin
        r_data  <= w_relu;
        r_valid <= 1'b1;
      end else if (r_valid && m_ready_y) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_data_out_y = r_data;
  assign m_valid_y    = r_valid;

endmodule

// File: tb/tb_pool_relu_13_2_12.sv
// tb/tb_pool_relu_13_2_12.sv - directed-vector self-checking bench for pool_relu_13_2_12
`timescale 1ns/1ps

module tb_pool_relu_13_2_12;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] din = '0;
  logic               vld = 1'b0;
  logic               mrdy = 1'b0;

  logic               s_ready, k1_s_ready, k13_s_ready;
  logic signed [11:0] m_data, k1_data, k13_data;
  logic               m_valid, k1_valid, k13_valid;

  pool_relu_13_2_12 #(.L(13), .K(2), .T(12)) dut (
    .clk(clk), .reset(rst_n),
    .s_data_in_x(din), .s_valid_x(vld), .s_ready_x(s_ready),
    .m_data_out_y(m_data), .m_valid_y(m_valid), .m_ready_y(mrdy)
  );

  pool_relu_13_2_12 #(.L(13), .K(1), .T(12)) dut_k1 (
    .clk(clk), .reset(rst_n),
    .s_data_in_x(din), .s_valid_x(vld), .s_ready_x(k1_s_ready),
    .m_data_out_y(k1_data), .m_valid_y(k1_valid), .m_ready_y(mrdy)
  );

  pool_relu_13_2_12 #(.L(13), .K(13), .T(12)) dut_k13 (
    .clk(clk), .reset(rst_n),
    .s_data_in_x(din), .s_valid_x(vld), .s_ready_x(k13_s_ready),
    .m_data_out_y(k13_data), .m_valid_y(k13_valid), .m_ready_y(mrdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_mode = 1'b0;
  int last_acc = 0;

  int out_q[$];
  int out_cyc_q[$];
  int k1_q[$];
  int k13_q[$];
  int exp_q[$];

  always @(negedge clk) begin
    if (rst_n && mrdy) begin
      if (m_valid) begin
        out_q.push_back(int'(m_data));
        out_cyc_q.push_back(cyc);
      end
      if (k1_valid)  k1_q.push_back(int'(k1_data));
      if (k13_valid) k13_q.push_back(int'(k13_data));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) mrdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_elem(input int x);
    bit acc;
    int guard;
    if (rand_mode) begin
      while ($urandom_range(0, 2) == 0) begin
        vld = 1'b0;
        tick();
      end
    end
    vld = 1'b1;
    din = 12'(x);
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = s_ready;
      if (acc) last_acc = cyc;
      tick();
      guard++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    vld = 1'b0;
  endtask

  task automatic wait_outs(input int n, input string tag);
    int guard;
    guard = 0;
    while (out_q.size() < n && guard < 300) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check_eq(tag, out_q.size(), n);
  endtask

  function automatic int pool_out(input int v[13], input int k, input int j);
    int m, hi;
    m  = v[j*k];
    hi = (j + 1) * k;
    if (hi > 13) hi = 13;
    for (int i = j*k + 1; i < hi; i++) if (v[i] > m) m = v[i];
    return (m < 0) ? 0 : m;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -99999;
  endfunction

  int v1[13]    = '{-5, 3, 7, -2, -8, -9, 0, 4, 100, 99, -1, -1, -6};
  int exp1[7]   = '{3, 7, 0, 4, 100, 0, 0};
  int close1[7] = '{1, 3, 5, 7, 9, 11, 12};
  int vneg[13]  = '{-7, -3, -100, -1, -2048, -5, -9, -4, -6, -8, -10, -11, -12};
  int vrst[13]  = '{1, 2, 3, 4, 50, 60, 7, 8, 9, 10, 11, 12, 13};
  int exp_k1[13] = '{0, 3, 7, 0, 0, 0, 0, 4, 100, 99, 0, 0, 0};
  int acc_cyc[13];
  int vr[13];

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_s_ready", s_ready, 1);
    #2 rst_n = 1'b1;
    tick();

    // single vector at full throughput, with latency
    out_q.delete(); out_cyc_q.delete();
    mrdy = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send_elem(v1[i]);
      acc_cyc[i] = last_acc;
    end
    wait_outs(7, "t1_count");
    check_eq("t1_in_no_bubble", acc_cyc[12], acc_cyc[0] + 12);
    for (int j = 0; j < 7; j++) begin
      check_eq($sformatf("t1_val%0d", j), q_at(out_q, j), exp1[j]);
      check_eq($sformatf("t1_lat%0d", j), q_at(out_cyc_q, j), acc_cyc[close1[j]] + 1);
    end

    // extremes
    out_q.delete(); out_cyc_q.delete();
    for (int i = 0; i < 13; i++) send_elem(-2048);
    for (int i = 0; i < 13; i++) send_elem(2047);
    wait_outs(14, "ext_count");
    for (int j = 0; j < 14; j++)
      check_eq($sformatf("ext_val%0d", j), q_at(out_q, j), (j < 7) ? 0 : 2047);

    // backpressure
    out_q.delete(); out_cyc_q.delete();
    mrdy = 1'b0;
    send_elem(v1[0]);
    send_elem(v1[1]);
    vld = 1'b1;
    din = 12'(v1[2]);
    @(negedge clk);
    check_eq("bp_open_ready", s_ready, 1);
    tick();
    din = 12'(v1[3]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("bp_stall_ready%0d", c), s_ready, 0);
      check_eq($sformatf("bp_hold_valid%0d", c), m_valid, 1);
      check_eq($sformatf("bp_hold_data%0d", c), m_data, 3);
      tick();
    end
    mrdy = 1'b1;
    for (int i = 3; i < 13; i++) send_elem(v1[i]);
    wait_outs(7, "bp_count");
    for (int j = 0; j < 7; j++)
      check_eq($sformatf("bp_val%0d", j), q_at(out_q, j), exp1[j]);

    // randomized handshakes against the pooling model
    out_q.delete(); out_cyc_q.delete(); exp_q.delete();
    rand_mode = 1'b1;
    for (int n = 0; n < 625; n++) begin
      for (int i = 0; i < 13; i++) vr[i] = int'($urandom_range(0, 4095)) - 2048;
      for (int j = 0; j < 7; j++) exp_q.push_back(pool_out(vr, 2, j));
      for (int i = 0; i < 13; i++) send_elem(vr[i]);
    end
    rand_mode = 1'b0;
    mrdy = 1'b1;
    wait_outs(4375, "rand_count");
    for (int j = 0; j < 4375; j++)
      check_eq($sformatf("rand_val%0d", j), q_at(out_q, j), exp_q[j]);

    // asynchronous reset mid-vector with an output pending
    mrdy = 1'b1;
    for (int i = 0; i < 5; i++) send_elem(vrst[i]);
    mrdy = 1'b0;
    send_elem(vrst[5]);
    check_eq("ar_pending_valid", m_valid, 1);
    check_eq("ar_pending_data", m_data, 60);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid_drop", m_valid, 0);
    check_eq("ar_data_clear", m_data, 0);
    check_eq("ar_ready", s_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_q.delete(); out_cyc_q.delete();
    mrdy = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) send_elem(v1[i]);
    wait_outs(7, "ar_count");
    for (int j = 0; j < 7; j++)
      check_eq($sformatf("ar_val%0d", j), q_at(out_q, j), exp1[j]);

    // parameter sweep: K = 1 and K = 13 instances
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    k1_q.delete(); k13_q.delete(); out_q.delete(); out_cyc_q.delete();
    mrdy = 1'b1;
    tick();
    check_eq("k1_ready", k1_s_ready, 1);
    for (int i = 0; i < 13; i++) send_elem(v1[i]);
    for (int i = 0; i < 13; i++) send_elem(vneg[i]);
    for (int g = 0; g < 300 && (k1_q.size() < 26 || k13_q.size() < 2); g++) tick();
    tick();
    tick();
    check_eq("k1_count", k1_q.size(), 26);
    check_eq("k13_count", k13_q.size(), 2);
    for (int j = 0; j < 26; j++)
      check_eq($sformatf("k1_val%0d", j), q_at(k1_q, j), (j < 13) ? exp_k1[j] : 0);
    check_eq("k13_val0", q_at(k13_q, 0), 100);
    check_eq("k13_val1", q_at(k13_q, 1), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
